// File: rtl/char_display_pkg.sv
// Shared constants, cell layout and FSM encoding for the character display engine.
// Optional blink attribute bit is enabled by defining CHAR_DISPLAY_CTRL_BLINK_EN.
package char_display_pkg;

  localparam int unsigned GLYPH_W     = 8;
  localparam int unsigned GLYPH_H     = 8;
  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam int unsigned CHAR_W      = 8;
  localparam int unsigned ADDR_W      = 14;

  localparam int unsigned FG_LSB = 0;
  localparam int unsigned BG_LSB = 3;
`ifdef CHAR_DISPLAY_CTRL_BLINK_EN
  localparam int unsigned BLINK_BIT = 6;
  localparam int unsigned ATTR_W    = 7;
`else
  localparam int unsigned ATTR_W    = 6;
`endif
  localparam int unsigned CELL_W = CHAR_W + ATTR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCROLL_FILL
  } state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] row,
                                                  input logic [6:0] col,
                                                  input logic [ADDR_W-1:0] cols);
    return ADDR_W'(row) * cols + ADDR_W'(col);
  endfunction

  // Both operands are below rows, so a single conditional subtract is a full modulo.
  function automatic logic [6:0] wrap_row(input logic [6:0] row,
                                          input logic [6:0] top,
                                          input logic [7:0] rows);
    logic [7:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= rows) sum = sum - rows;
    return sum[6:0];
  endfunction

endpackage

// File: rtl/char_glyph_rom.sv
// 8x8 font ROM with one-cycle registered read; pixel column 0 is the row MSB.
// Carries space, 'A' and 'X' glyphs; other codes render a hollow box. (CHAR_DISPLAY_CTRL_BLINK_EN: no effect here.)
module char_glyph_rom
  import char_display_pkg::*;
(
  input  logic                clk,
  input  logic [CHAR_W-1:0]   char_code,
  input  logic [2:0]          line,
  output logic [GLYPH_W-1:0]  row
);

  function automatic logic [GLYPH_W*GLYPH_H-1:0] glyph(input logic [CHAR_W-1:0] c);
    case (c)
      8'h00, ASCII_SPACE: return '0;
      8'h41:              return 64'h183C_6666_7E66_6600;
      8'h58:              return 64'h6666_3C18_3C66_6600;
      default:            return 64'h7E42_4242_4242_7E00;
    endcase
  endfunction

  logic [GLYPH_W*GLYPH_H-1:0] bits;
  logic [5:0]                 base;

  always_comb begin
    bits = glyph(char_code);
    base = {~line, 3'b000};
  end

  always_ff @(posedge clk) begin
    row <= bits[base +: GLYPH_W];
  end

endmodule

// File: rtl/char_display_ctrl.sv
// Text-mode display engine: scrollable cell RAM, clear/scroll fill FSM, 3-stage pixel pipeline.
// Define CHAR_DISPLAY_CTRL_BLINK_EN to add a blink attribute bit and frame counter.
module char_display_ctrl
  import char_display_pkg::*;
#(
  parameter int unsigned COLS     = 56,
  parameter int unsigned ROWS     = 33,
  parameter int unsigned COLOR_W  = 1,
  parameter logic [5:0]  DEF_ATTR = 6'b000_111
) (
  input  logic               pixel_clock,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [6:0]         char_column,
  input  logic [6:0]         char_line,
  input  logic [2:0]         subchar_line,
  input  logic [2:0]         subchar_pixel,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [6:0]         wr_col,
  input  logic [6:0]         wr_row,
  input  logic [7:0]         wr_char,
`ifdef CHAR_DISPLAY_CTRL_BLINK_EN
  input  logic [6:0]         wr_attr,
`else
  input  logic [5:0]         wr_attr,
`endif
  input  logic               scroll_req,
  input  logic               clear_req,
  output logic               busy,
  output logic [COLOR_W-1:0] vga_red,
  output logic [COLOR_W-1:0] vga_green,
  output logic [COLOR_W-1:0] vga_blue,
  output logic               vga_valid
);

  localparam int unsigned       CELLS     = ROWS * COLS;
  localparam int unsigned       RAM_AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [7:0]        ROWS_L    = 8'(ROWS);
  localparam logic [7:0]        COLS_L    = 8'(COLS);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
  localparam logic [CELL_W-1:0] FILL_CELL = {ASCII_SPACE, ATTR_W'(DEF_ATTR)};

  logic [CELL_W-1:0] cell_ram [CELLS];

  state_t            state, state_next;
  logic [ADDR_W-1:0] fill_cnt, fill_base;
  logic [6:0]        top_row;
  logic              wr_en;
  logic [RAM_AW-1:0] wr_addr;
  logic [CELL_W-1:0] wr_data;
  logic              host_in_range;

  always_comb begin
    host_in_range = ({1'b0, wr_col} < COLS_L) && ({1'b0, wr_row} < ROWS_L);
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (clear_req)       state_next = ST_CLEAR;
        else if (scroll_req) state_next = ST_SCROLL_FILL;
      end
      ST_CLEAR:       if (fill_cnt == LAST_CELL) state_next = ST_IDLE;
      ST_SCROLL_FILL: if (fill_cnt == LAST_COL)  state_next = ST_IDLE;
      default:        state_next = ST_CLEAR;
    endcase
  end

  // fill_cnt is parked at zero in IDLE so every fill starts from its first cell.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      fill_cnt  <= '0;
      fill_base <= '0;
      top_row   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          fill_cnt <= '0;
          if (!clear_req && scroll_req) begin
            fill_base <= cell_addr(top_row, 7'd0, COLS_A);
            top_row   <= wrap_row(top_row, 7'd1, ROWS_L);
          end
        end
        ST_CLEAR: begin
          fill_cnt <= fill_cnt + ADDR_W'(1);
          if (fill_cnt == LAST_CELL) top_row <= '0;
        end
        ST_SCROLL_FILL: fill_cnt <= fill_cnt + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = FILL_CELL;
    case (state)
      ST_IDLE: begin
        wr_ready = !reset && !clear_req && !scroll_req;
        wr_en    = wr_ready && wr_valid && host_in_range;
        wr_addr  = RAM_AW'(cell_addr(wrap_row(wr_row, top_row, ROWS_L), wr_col, COLS_A));
        wr_data  = {wr_char, wr_attr};
      end
      ST_CLEAR: begin
        busy    = !reset;
        wr_en   = !reset;
        wr_addr = RAM_AW'(fill_cnt);
      end
      ST_SCROLL_FILL: begin
        busy    = !reset;
        wr_en   = !reset;
        wr_addr = RAM_AW'(fill_base + fill_cnt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge pixel_clock) begin
    if (wr_en) cell_ram[wr_addr] <= wr_data;
  end

  logic              s1_valid, s1_in, s2_valid, s2_in, s3_valid, s3_in;
  logic [RAM_AW-1:0] s1_addr;
  logic [2:0]        s1_sline, s1_spix, s2_sline, s2_spix, s3_spix;
  logic [CELL_W-1:0] s2_cell;
  logic [ATTR_W-1:0] s3_attr;
  logic [7:0]        glyph_row;
  logic              pix_on, blank;
  logic [2:0]        rgb;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_in    <= 1'b0;
      s2_valid <= 1'b0;
      s2_in    <= 1'b0;
      s3_valid <= 1'b0;
      s3_in    <= 1'b0;
    end else begin
      s1_valid <= pix_valid;
      s1_in    <= pix_valid && ({1'b0, char_column} < COLS_L) && ({1'b0, char_line} < ROWS_L);
      s2_valid <= s1_valid;
      s2_in    <= s1_in;
      s3_valid <= s2_valid;
      s3_in    <= s2_in;
    end
  end

  always_ff @(posedge pixel_clock) begin
    s1_addr  <= RAM_AW'(cell_addr(wrap_row(char_line, top_row, ROWS_L), char_column, COLS_A));
    s1_sline <= subchar_line;
    s1_spix  <= subchar_pixel;
    s2_cell  <= cell_ram[s1_addr];
    s2_sline <= s1_sline;
    s2_spix  <= s1_spix;
    s3_attr  <= s2_cell[ATTR_W-1:0];
    s3_spix  <= s2_spix;
  end

  char_glyph_rom u_glyph_rom (
    .clk       (pixel_clock),
    .char_code (s2_cell[CELL_W-1 -: CHAR_W]),
    .line      (s2_sline),
    .row       (glyph_row)
  );

`ifdef CHAR_DISPLAY_CTRL_BLINK_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge pixel_clock) begin
    if (reset) frame_cnt <= '0;
    else if (!pix_valid && char_line == '0 && char_column == '0 &&
             subchar_line == '0 && subchar_pixel == '0)
      frame_cnt <= frame_cnt + 6'd1;
  end

  always_comb blank = s3_attr[BLINK_BIT] && frame_cnt[5];
`else
  always_comb blank = 1'b0;
`endif

  always_comb begin
    pix_on = glyph_row[~s3_spix];
    if (!s3_in)              rgb = '0;
    else if (pix_on && !blank) rgb = s3_attr[FG_LSB +: 3];
    else                     rgb = s3_attr[BG_LSB +: 3];
    vga_red   = {COLOR_W{rgb[2]}};
    vga_green = {COLOR_W{rgb[1]}};
    vga_blue  = {COLOR_W{rgb[0]}};
    vga_valid = s3_valid;
  end

endmodule
